// File: rtl/ddr3_frame_writer.sv
// rtl/ddr3_frame_writer.sv - packs 32-bit pixels into 128-bit words and burst-writes frames over Avalon-MM
// Optional stall counter is built when DDR3_WRITER_STATS_EN is defined.
module ddr3_frame_writer #(
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [25:0]  frame_base_addr,
    input  logic [25:0]  frame_words,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic         pix_sof,
    input  logic [31:0]  pix_data,
    input  logic         ddr3_avl_ready,
    output logic         ddr3_avl_burstbegin,
    output logic [2:0]   ddr3_avl_size,
    output logic         ddr3_avl_write_req,
    output logic [127:0] ddr3_avl_wr_data,
    output logic [25:0]  ddr3_avl_addr,
    output logic         frame_done,
    output logic         busy,
    output logic         sof_err,
    output logic [15:0]  stall_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;
    localparam logic [2:0]    BL3      = 3'(BURST_LEN);
    localparam logic [25:0]   BL26     = 26'(BURST_LEN);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [95:0]   pack_q, pack_d;
    logic          frame_active_q, frame_active_d;
    logic [25:0]   wptr_q, wptr_d;
    logic [25:0]   remaining_q, remaining_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [25:0]   addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic [2:0]    beat_q, beat_d;
    logic          burstbegin_q, burstbegin_d;
    logic          write_req_q, write_req_d;
    logic          done_q, done_d;
    logic          sof_err_q, sof_err_d;

    logic [127:0]  fifo_mem [FIFO_DEPTH];
    logic          push;
    logic [127:0]  push_data;
    logic          fifo_full;
    logic          pix_acc;
    logic          beat;
    logic          last_beat;
    logic [25:0]   rem_after;
    logic          frame_end;
    logic          frame_free;
    logic          frame_start;
    logic [2:0]    size_calc;

    always_comb begin
        fifo_full   = (fifo_cnt_q == FULL_CNT);
        pix_ready   = enable && !(lane_q == 2'd3 && fifo_full);
        pix_acc     = pix_valid && pix_ready;
        beat        = write_req_q && ddr3_avl_ready;
        last_beat   = beat && (beat_q == size_q - 3'd1);
        rem_after   = remaining_q - {23'd0, size_q};
        frame_end   = last_beat && (rem_after == 26'd0);
        // A frame finishing this cycle frees the slot for a back-to-back start.
        frame_free  = !frame_active_q || frame_end;
        frame_start = pix_acc && pix_sof && frame_free;
        size_calc   = (remaining_q < BL26) ? remaining_q[2:0] : BL3;
    end

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        pack_d         = pack_q;
        frame_active_d = frame_active_q;
        wptr_d         = wptr_q;
        remaining_d    = remaining_q;
        addr_d         = addr_q;
        size_d         = size_q;
        beat_d         = beat_q;
        burstbegin_d   = burstbegin_q;
        write_req_d    = write_req_q;
        done_d         = 1'b0;
        sof_err_d      = sof_err_q;
        push           = 1'b0;
        push_data      = {pix_data, pack_q};

        case (state_q)
            ST_IDLE: begin
                if (size_calc != 3'd0 &&
                    {{(32-CW){1'b0}}, fifo_cnt_q} >= {29'd0, size_calc}) begin
                    state_d      = ST_BURST;
                    addr_d       = wptr_q;
                    size_d       = size_calc;
                    beat_d       = 3'd0;
                    burstbegin_d = 1'b1;
                    write_req_d  = 1'b1;
                end
            end
            ST_BURST: begin
                if (beat) begin
                    burstbegin_d = 1'b0;
                    beat_d       = beat_q + 3'd1;
                    if (last_beat) begin
                        write_req_d = 1'b0;
                        state_d     = ST_IDLE;
                        wptr_d      = wptr_q + {23'd0, size_q};
                        remaining_d = rem_after;
                        if (frame_end) begin
                            done_d         = 1'b1;
                            frame_active_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_start) begin
            frame_active_d = 1'b1;
            wptr_d         = frame_base_addr;
            remaining_d    = frame_words;
            lane_d         = 2'd1;
            pack_d[31:0]   = pix_data;
        end else if (pix_acc && !frame_free) begin
            // A stray sof inside a frame is flagged but packed as ordinary data.
            if (pix_sof) begin
                sof_err_d = 1'b1;
            end
            case (lane_q)
                2'd0: begin pack_d[31:0]  = pix_data; lane_d = 2'd1; end
                2'd1: begin pack_d[63:32] = pix_data; lane_d = 2'd2; end
                2'd2: begin pack_d[95:64] = pix_data; lane_d = 2'd3; end
                default: begin push = 1'b1; lane_d = 2'd0; end
            endcase
        end

        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(beat);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(beat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            lane_q         <= 2'd0;
            pack_q         <= '0;
            frame_active_q <= 1'b0;
            wptr_q         <= '0;
            remaining_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            addr_q         <= '0;
            size_q         <= '0;
            beat_q         <= '0;
            burstbegin_q   <= 1'b0;
            write_req_q    <= 1'b0;
            done_q         <= 1'b0;
            sof_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            pack_q         <= pack_d;
            frame_active_q <= frame_active_d;
            wptr_q         <= wptr_d;
            remaining_q    <= remaining_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            beat_q         <= beat_d;
            burstbegin_q   <= burstbegin_d;
            write_req_q    <= write_req_d;
            done_q         <= done_d;
            sof_err_q      <= sof_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

`ifdef DDR3_WRITER_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = 16'd0;
        end else if (write_req_q && !ddr3_avl_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'd0;
`endif

    assign ddr3_avl_burstbegin = burstbegin_q;
    assign ddr3_avl_size       = size_q;
    assign ddr3_avl_write_req  = write_req_q;
    assign ddr3_avl_wr_data    = write_req_q ? fifo_mem[rd_ptr_q] : 128'd0;
    assign ddr3_avl_addr       = addr_q;
    assign frame_done          = done_q;
    assign busy                = frame_active_q || (fifo_cnt_q != '0) || write_req_q;
    assign sof_err             = sof_err_q;

endmodule
